// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus.
// Groups the decode-side instruction fields, the EX/MEM and MEM/WB forwarding
// sources and the EX-side outputs (ALU operands, registered control and the
// load-use hazard flag) into one bundle.
//   master : decode/pipeline control side (drives ID fields, forwarding, stall/flush)
//   slave  : the id_ex_operand_stage itself
interface id_ex_operand_stage_if #(
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned DATA_W    = 32
) ();
    // pipeline control
    logic                 stall;
    logic                 flush;
    // decoded instruction fields
    logic                 id_valid;
    logic [3:0]           id_ctl;
    logic [REG_IDX_W-1:0] id_rs_idx;
    logic [REG_IDX_W-1:0] id_rt_idx;
    logic [DATA_W-1:0]    id_rs_data;
    logic [DATA_W-1:0]    id_rt_data;
    logic [DATA_W-1:0]    id_imm;
    logic                 id_alu_src;
    logic [REG_IDX_W-1:0] id_rd_idx;
    logic                 id_reg_write;
    logic                 id_mem_read;
    // forwarding sources
    logic                 exmem_reg_write;
    logic [REG_IDX_W-1:0] exmem_rd_idx;
    logic [DATA_W-1:0]    exmem_value;
    logic                 memwb_reg_write;
    logic [REG_IDX_W-1:0] memwb_rd_idx;
    logic [DATA_W-1:0]    memwb_value;
    // EX-side outputs
    logic [3:0]           alu_ctl;
    logic [DATA_W-1:0]    alu_a;
    logic [DATA_W-1:0]    alu_b;
    logic [DATA_W-1:0]    ex_store_data;
    logic                 ex_valid;
    logic                 ex_reg_write;
    logic                 ex_mem_read;
    logic [REG_IDX_W-1:0] ex_rd_idx;
    logic                 load_use_hazard;

    modport master (
        output stall, flush, id_valid, id_ctl, id_rs_idx, id_rt_idx, id_rs_data,
               id_rt_data, id_imm, id_alu_src, id_rd_idx, id_reg_write, id_mem_read,
               exmem_reg_write, exmem_rd_idx, exmem_value,
               memwb_reg_write, memwb_rd_idx, memwb_value,
        input  alu_ctl, alu_a, alu_b, ex_store_data, ex_valid, ex_reg_write,
               ex_mem_read, ex_rd_idx, load_use_hazard
    );

    modport slave (
        input  stall, flush, id_valid, id_ctl, id_rs_idx, id_rt_idx, id_rs_data,
               id_rt_data, id_imm, id_alu_src, id_rd_idx, id_reg_write, id_mem_read,
               exmem_reg_write, exmem_rd_idx, exmem_value,
               memwb_reg_write, memwb_rd_idx, memwb_value,
        output alu_ctl, alu_a, alu_b, ex_store_data, ex_valid, ex_reg_write,
               ex_mem_read, ex_rd_idx, load_use_hazard
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, feeding the ALU directly.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (overrides stall and flush)
//   bus  : id_ex_operand_stage_if.slave -- ID fields, stall/flush, EX/MEM and
//          MEM/WB forwarding sources in; ALU ctl/a/b, store data, registered
//          control and the load-use hazard flag out.
// Edge priority: rst > flush > stall > capture. A bubble is an all-zero EX
// register, so its indices are 0 and it can never forward, write or hazard.
module id_ex_operand_stage #(
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned DATA_W    = 32
) (
    input logic                   clk,
    input logic                   rst,
    id_ex_operand_stage_if.slave  bus
);

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_read;
        logic                 alu_src;
        logic [3:0]           ctl;
        logic [REG_IDX_W-1:0] rd_idx;
        logic [REG_IDX_W-1:0] rs_idx;
        logic [REG_IDX_W-1:0] rt_idx;
        logic [DATA_W-1:0]    rs_data;
        logic [DATA_W-1:0]    rt_data;
        logic [DATA_W-1:0]    imm;
    } ex_t;

    ex_t ex_q, ex_d;

    logic [DATA_W-1:0] rs_cap, rt_cap;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    // Same-cycle register-file write: the RF read in ID is stale, take MEM/WB.
    function automatic logic [DATA_W-1:0] wb_bypass(
        input logic [REG_IDX_W-1:0] idx,
        input logic [DATA_W-1:0]    data,
        input logic                 wb_we,
        input logic [REG_IDX_W-1:0] wb_rd,
        input logic [DATA_W-1:0]    wb_val
    );
        if (wb_we && (wb_rd != '0) && (wb_rd == idx)) return wb_val;
        return data;
    endfunction

    // EX/MEM is younger than MEM/WB, so it wins; index 0 is hardwired zero.
    function automatic logic [DATA_W-1:0] forward(
        input logic [REG_IDX_W-1:0] idx,
        input logic [DATA_W-1:0]    data,
        input logic                 mem_we,
        input logic [REG_IDX_W-1:0] mem_rd,
        input logic [DATA_W-1:0]    mem_val,
        input logic                 wb_we,
        input logic [REG_IDX_W-1:0] wb_rd,
        input logic [DATA_W-1:0]    wb_val
    );
        if (idx == '0)                                      return '0;
        if (mem_we && (mem_rd != '0) && (mem_rd == idx))    return mem_val;
        if (wb_we && (wb_rd != '0) && (wb_rd == idx))       return wb_val;
        return data;
    endfunction

    always_comb begin
        rs_cap = wb_bypass(bus.id_rs_idx, bus.id_rs_data, bus.memwb_reg_write,
                           bus.memwb_rd_idx, bus.memwb_value);
        rt_cap = wb_bypass(bus.id_rt_idx, bus.id_rt_data, bus.memwb_reg_write,
                           bus.memwb_rd_idx, bus.memwb_value);
    end

    // Next-state for the EX register (reset handled in the register itself).
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (!bus.stall) begin
            if (bus.id_valid) begin
                ex_d.valid     = 1'b1;
                ex_d.reg_write = bus.id_reg_write;
                ex_d.mem_read  = bus.id_mem_read;
                ex_d.alu_src   = bus.id_alu_src;
                ex_d.ctl       = bus.id_ctl;
                ex_d.rd_idx    = bus.id_rd_idx;
                ex_d.rs_idx    = bus.id_rs_idx;
                ex_d.rt_idx    = bus.id_rt_idx;
                ex_d.rs_data   = rs_cap;
                ex_d.rt_data   = rt_cap;
                ex_d.imm       = bus.id_imm;
            end else begin
                ex_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Forwarding re-evaluates every cycle, including while stalled.
    always_comb begin
        rs_fwd = forward(ex_q.rs_idx, ex_q.rs_data,
                         bus.exmem_reg_write, bus.exmem_rd_idx, bus.exmem_value,
                         bus.memwb_reg_write, bus.memwb_rd_idx, bus.memwb_value);
        rt_fwd = forward(ex_q.rt_idx, ex_q.rt_data,
                         bus.exmem_reg_write, bus.exmem_rd_idx, bus.exmem_value,
                         bus.memwb_reg_write, bus.memwb_rd_idx, bus.memwb_value);
    end

    assign bus.alu_ctl       = ex_q.ctl;
    assign bus.alu_a         = rs_fwd;
    assign bus.alu_b         = ex_q.alu_src ? ex_q.imm : rt_fwd;
    assign bus.ex_store_data = rt_fwd;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_rd_idx     = ex_q.rd_idx;

    assign bus.load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd_idx != '0) &&
                                 ((ex_q.rd_idx == bus.id_rs_idx) ||
                                  (ex_q.rd_idx == bus.id_rt_idx)) &&
                                 bus.id_valid;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that feeds the ALU directly.
- Latches decoded instruction fields on each clock and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's ctl/a/b inputs and raises a load-use hazard flag back to the decode/fetch stall logic.

Parameters:
- REG_IDX_W, 5, register index width (32 GPRs, index 0 hardwired zero)
- DATA_W, 32, datapath width

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold EX register contents
- flush  input  1  load a bubble into EX
- id_valid  input  1  ID holds a real instruction
- id_ctl  input  4  ALU op code (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 lui)
- id_rs_idx, id_rt_idx  input  5 each  source register indices
- id_rs_data, id_rt_data  input  32 each  register-file read data
- id_imm  input  32  already-extended immediate
- id_alu_src  input  1  1 selects imm as operand B
- id_rd_idx  input  5  destination index
- id_reg_write  input  1  instruction writes rd
- id_mem_read  input  1  instruction is a load
- exmem_reg_write  input  1  EX/MEM writes a register
- exmem_rd_idx  input  5  EX/MEM destination index
- exmem_value  input  32  EX/MEM result
- memwb_reg_write  input  1  MEM/WB writes a register
- memwb_rd_idx  input  5  MEM/WB destination index
- memwb_value  input  32  MEM/WB result
- alu_ctl  output  4  to ALU ctl
- alu_a, alu_b  output  32 each  to ALU a/b
- ex_store_data  output  32  forwarded rt value for stores
- ex_valid, ex_reg_write, ex_mem_read  output  1 each  registered control
- ex_rd_idx  output  5  registered destination index
- load_use_hazard  output  1  request one-cycle stall of IF/ID

Behaviour:
- Reset (rst=1 at an edge): all EX registers cleared. ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_rd_idx=0, alu_ctl=0. alu_a, alu_b and ex_store_data read 0 because index 0 is never forwarded. load_use_hazard=0. Reset overrides stall and flush.
- Edge priority: rst > flush > stall > capture.
  - flush: load a bubble (all fields zero).
  - stall without flush: hold all registers.
  - Otherwise: capture the ID fields. When id_valid=0, capture a bubble.
- Capture-time bypass (register-file write in the same cycle):
  - If memwb_reg_write, memwb_rd_idx!=0 and memwb_rd_idx==id_rs_idx, latch memwb_value instead of id_rs_data.
  - Same rule for rt.
- EX forwarding (combinational from the registered indices), per operand:
  - EX/MEM match (reg_write=1, rd!=0, rd==idx) is taken first.
  - Otherwise a MEM/WB match is taken.
  - Otherwise the latched data is used.
  - Index 0 always yields 0.
- Operand outputs:
  - alu_a = forwarded rs.
  - alu_b = latched imm if alu_src=1, else forwarded rt.
  - ex_store_data = forwarded rt, regardless of alu_src.
- Latency: one cycle ID->EX. Forwarding adds no cycles.
- Load-use hazard (combinational) = ex_valid & ex_mem_read & ex_rd_idx!=0 & (ex_rd_idx==id_rs_idx | ex_rd_idx==id_rt_idx) & id_valid.
  - External logic asserts stall on IF/ID and flush on this block in response, inserting one bubble.
- Stall hold: forwarding continues to re-evaluate against current EX/MEM and MEM/WB inputs; the latched data is not refreshed.
- Bubbles:
  - A bubble never asserts ex_reg_write or ex_mem_read.
  - A bubble never matches a load-use hazard.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> every output 0, load_use_hazard=0. Release, capture add r3=r1+r2 (rs_data=5, rt_data=7) -> next cycle alu_a=5, alu_b=7, alu_ctl=0, ex_rd_idx=3.
- EX/MEM priority: EX holds rs=r4; exmem rd=4 value 0x11 and memwb rd=4 value 0x22 both active -> alu_a=0x11. Drop exmem_reg_write -> alu_a=0x22.
- r0 and immediate:
  - exmem_rd_idx=0, reg_write=1, value 0xFFFF, EX rs=r0 -> alu_a=0.
  - alu_src=1, imm=0x1234, rt forwarding active -> alu_b=0x1234 and ex_store_data=forwarded value.
- Load-use: EX holds lw r5 (mem_read=1), ID presents add using rt=r5 -> load_use_hazard=1. Next edge with flush=1 -> ex_valid=0, hazard=0.
- Capture bypass: at the capture edge memwb writes r6=0xABCD while id_rs_data=0 for rs=r6, forwarding idle next cycle -> alu_a=0xABCD.
- Flush vs stall: stall=1 and flush=1 together -> bubble loaded. Stall alone for 3 cycles -> ex_rd_idx/alu_ctl unchanged; alu_a tracks changing exmem_value on a matching index.
